// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: op codes, legality check
// and the arbiter FSM state type.
package alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_AND   = 4'b0000;
   localparam alu_op_t ALU_OR    = 4'b0001;
   localparam alu_op_t ALU_ADD   = 4'b0010;
   localparam alu_op_t ALU_SUB   = 4'b0110;
   localparam alu_op_t ALU_PASSB = 4'b0111;
   localparam alu_op_t ALU_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // True for the six op codes the ALU implements.
   function automatic logic alu_op_legal(alu_op_t op);
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the execute units (master) and the shared ALU
// arbiter (slave).
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0]             req_ready;
   logic [N_REQ-1:0][63:0]       req_a;
   logic [N_REQ-1:0][63:0]       req_b;
   alu_op_t [N_REQ-1:0]          req_op;

   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [ID_W-1:0]              rsp_id;
   logic [63:0]                  rsp_result;
   logic                         rsp_zero;
   logic                         rsp_illegal;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
   );

endinterface

// File: rtl/alu.sv
// Shared 64-bit ALU: AND, OR, ADD, SUB, pass-B, NOR. Unknown codes yield zero.
module alu
   import alu_pkg::*;
(
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  alu_op_t     alu_control,
   output logic [63:0] result,
   output logic        zero
);

   // Result select on the control code; carries and borrows are dropped.
   always_comb begin
      result = '0;
      case (alu_control)
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_PASSB: result = b;
         ALU_NOR:   result = ~(a | b);
         default:   result = '0;
      endcase
   end

   assign zero = (result == 64'd0);

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request searching
// upward from ptr+1, wrapping, and returns it one-hot and as an index.
module rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             grant_valid
);

   // Scan N_REQ slots starting just past the last winner; ptr itself is checked last.
   always_comb begin
      int unsigned j;
      j           = 0;
      grant       = '0;
      idx         = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         j = (32'(ptr) + i) % N_REQ;
         if (!grant_valid && req[j]) begin
            grant_valid = 1'b1;
            grant       = N_REQ'(1) << j;
            idx         = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters. One op in flight: IDLE accepts, EXEC
// evaluates the latched operands, RESP holds the result until the consumer takes
// it and can accept the next op in that same cycle.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q;

   logic [63:0]      op_a_q;
   logic [63:0]      op_b_q;
   alu_op_t          op_q;
   logic [ID_W-1:0]  id_q;

   logic             rsp_valid_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic [63:0]      rsp_result_q;
   logic             rsp_zero_q;
   logic             rsp_illegal_q;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_valid;
   logic             arb_en;
   logic             accept;

   logic [63:0]      alu_result;
   logic             alu_zero;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req         (bus.req_valid),
      .ptr         (rr_ptr_q),
      .grant       (grant),
      .idx         (grant_idx),
      .grant_valid (grant_valid)
   );

   alu u_alu (
      .a           (op_a_q),
      .b           (op_b_q),
      .alu_control (op_q),
      .result      (alu_result),
      .zero        (alu_zero)
   );

   // Arbitration is open when idle, or in RESP while the held response drains.
   always_comb begin
      arb_en        = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
      accept        = arb_en && grant_valid;
      bus.req_ready = arb_en ? grant : '0;
      state_d       = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = accept ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and round-robin pointer; the pointer moves only on an accepted handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) rr_ptr_q <= grant_idx;
      end
   end

   // Operand capture from the granted requester.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a_q <= '0;
         op_b_q <= '0;
         op_q   <= ALU_AND;
         id_q   <= '0;
      end else if (accept) begin
         op_a_q <= bus.req_a[grant_idx];
         op_b_q <= bus.req_b[grant_idx];
         op_q   <= bus.req_op[grant_idx];
         id_q   <= grant_idx;
      end
   end

   // Response register: loaded at the end of EXEC, held until rsp_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else if (state_q == EXEC) begin
         rsp_valid_q   <= 1'b1;
         rsp_id_q      <= id_q;
         rsp_result_q  <= alu_result;
         rsp_zero_q    <= alu_zero;
         rsp_illegal_q <= ~alu_op_legal(op_q);
      end else if ((state_q == RESP) && bus.rsp_ready) begin
         rsp_valid_q   <= 1'b0;
      end
   end

   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_illegal = rsp_illegal_q;

endmodule
